// File: rtl/sr_checker.sv
`default_nettype none
// ============================================================================
//  Module   : sr_checker
//  Purpose  : Response checker for an S/R latch. Tracks the S/R stimulus the
//             latch sees, models the expected Q, and compares the latch's
//             Q/Qb against that model once the inputs have settled. Forbidden
//             S=R=1 inputs are detected and never checked.
//  Ports    : clk          - system clock, rising edge
//             rst_n        - asynchronous active-low reset
//             en           - check enable (synchronous)
//             clr          - synchronous clear of counters and err
//             s, r         - latch stimulus (asynchronous to clk)
//             q, qb        - latch outputs (asynchronous to clk)
//             state        - 0=UNKN 1=WAIT 2=CHECK 3=INVAL
//             exp_q        - modelled expected Q
//             exp_valid    - exp_q is meaningful
//             inv          - high while in INVAL
//             err          - sticky mismatch flag
//             mismatch_cnt - failed compares, saturating
//             check_cnt    - total compares, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module sr_checker #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qb,
    output logic [1:0]       state,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             inv,
    output logic             err,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] check_cnt
);

    localparam logic [1:0]       ST_UNKN   = 2'd0;
    localparam logic [1:0]       ST_WAIT   = 2'd1;
    localparam logic [1:0]       ST_CHECK  = 2'd2;
    localparam logic [1:0]       ST_INVAL  = 2'd3;

    localparam logic [3:0]       C_SETTLE  = 4'(SETTLE);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Synchronizer bit order: {s, r, q, qb}
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [1:0]       r_prev;
    logic [1:0]       r_state;
    logic             r_exp_q;
    logic             r_exp_valid;
    logic [3:0]       r_settle;
    logic             r_err;
    logic [CNT_W-1:0] r_mism;
    logic [CNT_W-1:0] r_chk;

    logic [1:0]       w_sr;
    logic             w_q2;
    logic             w_qb2;
    logic             w_change;
    logic             w_load;
    logic [1:0]       w_state_nxt;
    logic             w_exp_q_nxt;
    logic             w_exp_valid_nxt;
    logic [3:0]       w_settle_nxt;
    logic             w_compare;
    logic             w_fail;

    assign w_sr     = r_sync2[3:2];
    assign w_q2     = r_sync2[1];
    assign w_qb2    = r_sync2[0];
    assign w_change = (w_sr != r_prev);

    // Synchronizers and change-detect history run regardless of en, so that
    // re-enabling with a steady input does not look like a fresh change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
            r_prev  <= 2'd0;
        end else begin
            r_sync1 <= {s, r, q, qb};
            r_sync2 <= r_sync1;
            r_prev  <= w_sr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_UNKN;
            r_exp_q     <= 1'b0;
            r_exp_valid <= 1'b0;
            r_settle    <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_exp_q     <= w_exp_q_nxt;
            r_exp_valid <= w_exp_valid_nxt;
            r_settle    <= w_settle_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_exp_q_nxt     = r_exp_q;
        w_exp_valid_nxt = r_exp_valid;
        w_settle_nxt    = r_settle;
        w_load          = 1'b0;
        w_compare       = 1'b0;

        if (!en) begin
            w_state_nxt     = ST_UNKN;
            w_exp_valid_nxt = 1'b0;
        end else if (w_change) begin
            // Any input change re-targets the FSM, whatever state it is in.
            case (w_sr)
                2'b11: begin
                    w_state_nxt     = ST_INVAL;
                    w_exp_valid_nxt = 1'b0;
                end
                2'b10, 2'b01: begin
                    w_exp_q_nxt     = w_sr[1];
                    w_exp_valid_nxt = 1'b1;
                    w_load          = 1'b1;
                end
                default: begin
                    // 00 keeps the latch state only if we knew it beforehand;
                    // after a forbidden input the latch state is undefined.
                    if (r_exp_valid) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_UNKN;
                    end
                end
            endcase
        end else begin
            case (r_state)
                ST_WAIT: begin
                    w_settle_nxt = r_settle - 4'd1;
                    if (r_settle <= 4'd1) begin
                        w_state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    w_compare = 1'b1;
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end

        if (w_load) begin
            w_settle_nxt = C_SETTLE;
            w_state_nxt  = (C_SETTLE == 4'd0) ? ST_CHECK : ST_WAIT;
        end
    end

    assign w_fail = w_compare && !((w_q2 == r_exp_q) && (w_qb2 == ~r_exp_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err  <= 1'b0;
            r_mism <= '0;
            r_chk  <= '0;
        end else if (clr) begin
            r_err  <= 1'b0;
            r_mism <= '0;
            r_chk  <= '0;
        end else begin
            if (w_compare && (r_chk != C_CNT_MAX)) begin
                r_chk <= r_chk + C_CNT_ONE;
            end
            if (w_fail) begin
                r_err <= 1'b1;
                if (r_mism != C_CNT_MAX) begin
                    r_mism <= r_mism + C_CNT_ONE;
                end
            end
        end
    end

    assign state        = r_state;
    assign exp_q        = r_exp_q;
    assign exp_valid    = r_exp_valid;
    assign inv          = (r_state == ST_INVAL);
    assign err          = r_err;
    assign mismatch_cnt = r_mism;
    assign check_cnt    = r_chk;

endmodule
`default_nettype wire

// File: tb/tb_sr_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_checker
//  Purpose  : Directed self-checking bench for sr_checker. Stimulus pushes
//             cycle-stamped expectations into a scoreboard queue; a monitor
//             on the falling edge pops and compares entries due that cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_checker;

    localparam int SETTLE = 2;
    localparam int CNT_W  = 8;

    localparam int F_STATE = 0;
    localparam int F_EXPQ  = 1;
    localparam int F_EXPV  = 2;
    localparam int F_INV   = 3;
    localparam int F_ERR   = 4;
    localparam int F_MISM  = 5;
    localparam int F_CHK   = 6;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             en    = 1'b0;
    logic             clr   = 1'b0;
    logic             s     = 1'b0;
    logic             r     = 1'b0;
    logic             q     = 1'b0;
    logic             qb    = 1'b0;
    logic [1:0]       state;
    logic             exp_q;
    logic             exp_valid;
    logic             inv;
    logic             err;
    logic [CNT_W-1:0] mismatch_cnt;
    logic [CNT_W-1:0] check_cnt;

    sr_checker #(
        .SETTLE (SETTLE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .clr          (clr),
        .s            (s),
        .r            (r),
        .q            (q),
        .qb           (qb),
        .state        (state),
        .exp_q        (exp_q),
        .exp_valid    (exp_valid),
        .inv          (inv),
        .err          (err),
        .mismatch_cnt (mismatch_cnt),
        .check_cnt    (check_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        int fld;
        int val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic int actual(input int f);
        case (f)
            F_STATE: return int'(state);
            F_EXPQ:  return int'(exp_q);
            F_EXPV:  return int'(exp_valid);
            F_INV:   return int'(inv);
            F_ERR:   return int'(err);
            F_MISM:  return int'(mismatch_cnt);
            default: return int'(check_cnt);
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_STATE: return "state";
            F_EXPQ:  return "exp_q";
            F_EXPV:  return "exp_valid";
            F_INV:   return "inv";
            F_ERR:   return "err";
            F_MISM:  return "mismatch_cnt";
            default: return "check_cnt";
        endcase
    endfunction

    task automatic expect_at(input int c, input int f, input int v);
        exp_t e;
        e.at  = c;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic expect_reset(input int c);
        expect_at(c, F_STATE, 0);
        expect_at(c, F_EXPQ,  0);
        expect_at(c, F_EXPV,  0);
        expect_at(c, F_INV,   0);
        expect_at(c, F_ERR,   0);
        expect_at(c, F_MISM,  0);
        expect_at(c, F_CHK,   0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic si, input logic ri, input logic qi, input logic qbi);
        s  = si;
        r  = ri;
        q  = qi;
        qb = qbi;
    endtask

    // Scoreboard monitor: compares every entry due this cycle; an entry whose
    // cycle has already passed is reported as a failure.
    always @(negedge clk) begin : monitor
        int i;
        int a;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].at == cyc) begin
                a = actual(sb[i].fld);
                n_vec++;
                if (a != sb[i].val) begin
                    n_err++;
                    $display("FAIL %s @cycle %0d: got %0d, expected %0d",
                             fname(sb[i].fld), cyc, a, sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL %s @cycle %0d: not sampled, expected %0d at cycle %0d",
                         fname(sb[i].fld), cyc, sb[i].val, sb[i].at);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    // Toggle phases {s, r, q, qb} with expected values three cycles after the
    // drive (state, exp_q or -1 for don't-care, exp_valid, inv) and the
    // check count nine cycles after the drive.
    logic [3:0] ph      [6] = '{4'b1100, 4'b0001, 4'b1010, 4'b1100, 4'b0101, 4'b0001};
    int         ph_st   [6] = '{3, 0, 1, 3, 1, 1};
    int         ph_q    [6] = '{-1, -1, 1, -1, 0, 0};
    int         ph_v    [6] = '{0, 0, 1, 0, 1, 1};
    int         ph_inv  [6] = '{1, 0, 0, 1, 0, 0};
    int         ph_chk  [6] = '{0, 0, 4, 7, 11, 18};

    initial begin : stim
        int d;

        // Reset state
        tick(2);
        d = cyc;
        expect_reset(d);
        tick(1);
        rst_n = 1'b1;
        en    = 1'b1;
        tick(3);

        // Correct latch, S=1: two WAIT cycles, then CHECK and counting
        d = cyc;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        expect_at(d + 2, F_STATE, 0);
        expect_at(d + 3, F_STATE, 1);
        expect_at(d + 3, F_EXPQ,  1);
        expect_at(d + 3, F_EXPV,  1);
        expect_at(d + 4, F_STATE, 1);
        expect_at(d + 5, F_STATE, 2);
        expect_at(d + 5, F_CHK,   0);
        expect_at(d + 6, F_CHK,   1);
        expect_at(d + 9, F_CHK,   4);
        expect_at(d + 9, F_MISM,  0);
        expect_at(d + 9, F_ERR,   0);
        tick(10);

        // Faulty latch: Q stuck low while S=1
        d = cyc;
        q  = 1'b0;
        qb = 1'b1;
        expect_at(d + 2, F_ERR,  0);
        expect_at(d + 2, F_MISM, 0);
        expect_at(d + 3, F_ERR,  1);
        expect_at(d + 3, F_MISM, 1);
        expect_at(d + 3, F_CHK,  8);
        expect_at(d + 6, F_MISM, 4);
        tick(270);
        d = cyc;
        expect_at(d, F_MISM,  255);
        expect_at(d, F_CHK,   255);
        expect_at(d, F_ERR,   1);
        expect_at(d, F_STATE, 2);

        // One-cycle clear while mismatches continue
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        d = cyc;
        expect_at(d,     F_MISM,  0);
        expect_at(d,     F_CHK,   0);
        expect_at(d,     F_ERR,   0);
        expect_at(d,     F_STATE, 2);
        expect_at(d + 1, F_MISM,  1);
        expect_at(d + 1, F_CHK,   1);
        expect_at(d + 1, F_ERR,   1);
        expect_at(d + 3, F_MISM,  3);
        expect_at(d + 3, F_STATE, 2);
        tick(5);

        // Asynchronous reset mid-CHECK, released with en low
        en    = 1'b0;
        rst_n = 1'b0;
        d = cyc;
        expect_reset(d);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick(2);
        rst_n = 1'b1;
        d = cyc;
        expect_at(d + 5, F_STATE, 0);
        expect_at(d + 5, F_EXPV,  0);
        tick(8);
        en = 1'b1;
        d = cyc;
        expect_at(d + 6, F_STATE, 0);
        expect_at(d + 6, F_CHK,   0);
        tick(8);

        // S=0,R=1 checked, then en low drops to UNKN with counters held
        d = cyc;
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        expect_at(d + 3, F_STATE, 1);
        expect_at(d + 3, F_EXPQ,  0);
        expect_at(d + 3, F_EXPV,  1);
        expect_at(d + 5, F_STATE, 2);
        expect_at(d + 6, F_CHK,   1);
        expect_at(d + 8, F_CHK,   3);
        tick(8);
        en = 1'b0;
        d = cyc;
        expect_at(d + 2, F_STATE, 0);
        expect_at(d + 2, F_EXPV,  0);
        expect_at(d + 2, F_EXPQ,  0);
        expect_at(d + 2, F_CHK,   3);
        tick(3);
        en = 1'b1;
        d = cyc;
        expect_at(d + 5, F_STATE, 0);
        tick(6);

        // Slow toggling including forbidden inputs
        for (int p = 0; p < 6; p++) begin
            drive(ph[p][3], ph[p][2], ph[p][1], ph[p][0]);
            d = cyc;
            expect_at(d + 3, F_STATE, ph_st[p]);
            if (ph_q[p] >= 0) expect_at(d + 3, F_EXPQ, ph_q[p]);
            expect_at(d + 3, F_EXPV, ph_v[p]);
            expect_at(d + 3, F_INV,  ph_inv[p]);
            expect_at(d + 9, F_CHK,  ph_chk[p]);
            expect_at(d + 9, F_ERR,  0);
            expect_at(d + 9, F_MISM, 0);
            for (int i = 0; i < 10; i++) begin
                if (p == 0 && i == 2) clr = 1'b1;
                if (p == 0 && i == 3) clr = 1'b0;
                tick(1);
            end
        end

        // Inputs changing every cycle never settle into CHECK
        d = cyc;
        expect_at(d + 5,  F_STATE, 1);
        expect_at(d + 10, F_STATE, 1);
        expect_at(d + 15, F_STATE, 1);
        expect_at(d + 4,  F_CHK,   0);
        expect_at(d + 12, F_CHK,   0);
        expect_at(d + 20, F_CHK,   0);
        expect_at(d + 20, F_ERR,   0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 1) drive(1'b0, 1'b1, 1'b0, 1'b1);
            else            drive(1'b1, 1'b0, 1'b1, 1'b0);
            if (i == 2) clr = 1'b1;
            if (i == 3) clr = 1'b0;
            tick(1);
        end

        // Every queued entry is due well before this drain ends
        tick(20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
